// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared constants and types for the datapath bus arbiter
//
// Purpose: default requester count, 5-bit bus select codes for every bus
// source, and the arbiter state encoding.
// Ports: none (package).

package bus_arb_pkg;

  localparam int NUM_SRC_DEFAULT = 24;

  // Select codes fed to the 32-to-5 bus encoder; request bit i maps to code i.
  localparam logic [4:0] SEL_R0     = 5'd0;
  localparam logic [4:0] SEL_R1     = 5'd1;
  localparam logic [4:0] SEL_R2     = 5'd2;
  localparam logic [4:0] SEL_R3     = 5'd3;
  localparam logic [4:0] SEL_R4     = 5'd4;
  localparam logic [4:0] SEL_R5     = 5'd5;
  localparam logic [4:0] SEL_R6     = 5'd6;
  localparam logic [4:0] SEL_R7     = 5'd7;
  localparam logic [4:0] SEL_R8     = 5'd8;
  localparam logic [4:0] SEL_R9     = 5'd9;
  localparam logic [4:0] SEL_R10    = 5'd10;
  localparam logic [4:0] SEL_R11    = 5'd11;
  localparam logic [4:0] SEL_R12    = 5'd12;
  localparam logic [4:0] SEL_R13    = 5'd13;
  localparam logic [4:0] SEL_R14    = 5'd14;
  localparam logic [4:0] SEL_R15    = 5'd15;
  localparam logic [4:0] SEL_HI     = 5'd16;
  localparam logic [4:0] SEL_LO     = 5'd17;
  localparam logic [4:0] SEL_ZHI    = 5'd18;
  localparam logic [4:0] SEL_ZLO    = 5'd19;
  localparam logic [4:0] SEL_PC     = 5'd20;
  localparam logic [4:0] SEL_MDR    = 5'd21;
  localparam logic [4:0] SEL_INPORT = 5'd22;
  localparam logic [4:0] SEL_C      = 5'd23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational rotate-priority winner search
//
// Purpose: finds the first asserted request starting one past the last
// granted index, wrapping modulo NUM_SRC.
// Ports:
//   req      in  NUM_SRC  request vector
//   last     in  5        most recently granted index (always < NUM_SRC)
//   win_oh   out NUM_SRC  one-hot winner, zero when nothing requests
//   win_idx  out 5        binary index of the winner, zero when none
//   any      out 1        at least one request is asserted

module rr_pick #(
  parameter int NUM_SRC = 24
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [4:0]         last,
  output logic [NUM_SRC-1:0] win_oh,
  output logic [4:0]         win_idx,
  output logic               any
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  int          idx;
  logic [IW-1:0] sel;

  // Offset k = 1 is checked first so the previous owner (k = NUM_SRC) ranks last.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      sel = IW'(idx);
      if (!any && req[sel]) begin
        any         = 1'b1;
        win_idx     = 5'(idx);
        win_oh[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner arbiter for the internal datapath bus
//
// Purpose: grants the shared bus to one requester at a time, round-robin,
// with a one-cycle dead gap between owners. Optional hold limit is built
// when BUS_ARB_HOLD_LIMIT_EN is defined.
// Ports:
//   clock      in  1        rising-edge clock
//   clear      in  1        asynchronous active-high reset
//   req        in  NUM_SRC  per-source bus requests (bit i = select code i)
//   gnt        out NUM_SRC  registered one-hot grant, or zero
//   gnt_code   out 5        index of the granted bit, zero when no grant
//   gnt_valid  out 1        gnt is non-zero
//   bus_busy   out 1        arbiter is in GRANT or RELEASE

module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_DEFAULT,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [4:0]         gnt_code,
  output logic               gnt_valid,
  output logic               bus_busy
);

  if (NUM_SRC < 2 || NUM_SRC > 32 || MAX_HOLD < 1) begin : g_param_check
    $error("bus_arbiter: NUM_SRC must be 2..32 and MAX_HOLD at least 1");
  end

  localparam logic [4:0] LAST_RST = 5'(NUM_SRC - 1);

  arb_state_t         state;
  logic [4:0]         last;
  logic [NUM_SRC-1:0] pick_oh;
  logic [4:0]         pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               hold_expired;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req     (req),
    .last    (last),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // gnt is one-hot in GRANT, so this isolates the owner's own request.
  assign owner_req = |(req & gnt);

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;

  // hold_cnt is the number of GRANT cycles already served by the owner.
  assign hold_expired = (hold_cnt >= HOLD_W'(MAX_HOLD));
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_code  <= '0;
      gnt_valid <= 1'b0;
      bus_busy  <= 1'b0;
      last      <= LAST_RST;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      case (state)
        // RELEASE arbitrates exactly like IDLE; only bus_busy differs while in it.
        IDLE, RELEASE: begin
          if (pick_any) begin
            state     <= GRANT;
            gnt       <= pick_oh;
            gnt_code  <= pick_idx;
            gnt_valid <= 1'b1;
            bus_busy  <= 1'b1;
            last      <= pick_idx;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold_cnt  <= HOLD_W'(1);
`endif
          end else begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_code  <= '0;
            gnt_valid <= 1'b0;
            bus_busy  <= 1'b0;
          end
        end

        GRANT: begin
          if (!owner_req || hold_expired) begin
            state     <= RELEASE;
            gnt       <= '0;
            gnt_code  <= '0;
            gnt_valid <= 1'b0;
            bus_busy  <= 1'b1;
          end else begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold_cnt  <= hold_cnt + HOLD_W'(1);
`endif
          end
        end

        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_code  <= '0;
          gnt_valid <= 1'b0;
          bus_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter

module tb_bus_arbiter;

  localparam int N  = 24;
  localparam int MH = 4;

  logic         clock;
  logic         clear;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [4:0]   gnt_code;
  logic         gnt_valid;
  logic         bus_busy;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), whether a dead cycle is in
  // progress, the round-robin pointer and cycles served by the owner.
  int m_owner;
  bit m_rel;
  int m_last;
  int m_held;

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] g;
    logic [4:0]   c;
    logic         v;
    logic         b;
  } vec_t;

  vec_t tbl[22];

  bus_arbiter #(
    .NUM_SRC  (N),
    .MAX_HOLD (MH)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .req       (req),
    .gnt       (gnt),
    .gnt_code  (gnt_code),
    .gnt_valid (gnt_valid),
    .bus_busy  (bus_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rel   = 1'b0;
    m_last  = N - 1;
    m_held  = 0;
  endtask

  task automatic model_update(input logic [N-1:0] r, input logic c);
    bit drop;
    int i;
    if (c) begin
      model_reset();
    end else if (m_owner >= 0) begin
      drop = (r[m_owner] == 1'b0);
`ifdef BUS_ARB_HOLD_LIMIT_EN
      if (m_held >= MH) drop = 1'b1;
`endif
      if (drop) begin
        m_owner = -1;
        m_rel   = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_rel = 1'b0;
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (r[i]) begin
          m_owner = i;
          m_last  = i;
          m_held  = 1;
          break;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] eg;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check({tag, " gnt"},       32'(gnt),       eg);
    check({tag, " gnt_code"},  32'(gnt_code),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, " gnt_valid"}, 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check({tag, " bus_busy"},  32'(bus_busy),  (m_owner >= 0 || m_rel) ? 32'd1 : 32'd0);
  endtask

  // Drive inputs away from the active edge, let one rising edge happen,
  // advance the model, then settle before sampling.
  task automatic step(input logic [N-1:0] r, input logic c);
    @(negedge clock);
    clear = c;
    req   = r;
    @(posedge clock);
    model_update(r, c);
    #1;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] mask;
    logic [N-1:0] prev_g;
    logic         c;
    int           wt[N];
    int           maxw;
    bit           new_grant;
    logic [N-1:0] exp_g;

    clear = 1'b1;
    req   = '0;
    model_reset();

    // Reset held with R0 requesting: nothing granted until clear drops.
    step(24'h000001, 1'b1);
    step(24'h000001, 1'b1);
    check("reset gnt",       32'(gnt),       32'd0);
    check("reset gnt_valid", 32'(gnt_valid), 32'd0);
    check("reset bus_busy",  32'(bus_busy),  32'd0);
    check("reset gnt_code",  32'(gnt_code),  32'd0);
    step(24'h000001, 1'b0);
    check("first gnt",       32'(gnt),       32'h000001);
    check("first gnt_code",  32'(gnt_code),  32'd0);
    check("first gnt_valid", 32'(gnt_valid), 32'd1);

    // Table sequence starts from a fresh reset so the pointer is at NUM_SRC-1.
    tbl[0]  = '{24'h000003, 24'h000001, 5'd0,  1'b1, 1'b1};
    tbl[1]  = '{24'h000003, 24'h000001, 5'd0,  1'b1, 1'b1};
    tbl[2]  = '{24'h000002, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[3]  = '{24'h000002, 24'h000002, 5'd1,  1'b1, 1'b1};
    tbl[4]  = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[5]  = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b0};
    tbl[6]  = '{24'h000020, 24'h000020, 5'd5,  1'b1, 1'b1};
    tbl[7]  = '{24'h800021, 24'h000020, 5'd5,  1'b1, 1'b1};
    tbl[8]  = '{24'h800001, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[9]  = '{24'h800001, 24'h800000, 5'd23, 1'b1, 1'b1};
    tbl[10] = '{24'h800001, 24'h800000, 5'd23, 1'b1, 1'b1};
    tbl[11] = '{24'h000001, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[12] = '{24'h800001, 24'h000001, 5'd0,  1'b1, 1'b1};
    tbl[13] = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[14] = '{24'h100000, 24'h100000, 5'd20, 1'b1, 1'b1};
    tbl[15] = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[16] = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b0};
    tbl[17] = '{24'h000004, 24'h000004, 5'd2,  1'b1, 1'b1};
    tbl[18] = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[19] = '{24'h000004, 24'h000004, 5'd2,  1'b1, 1'b1};
    tbl[20] = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b1};
    tbl[21] = '{24'h000000, 24'h000000, 5'd0,  1'b0, 1'b0};

    step('0, 1'b1);
    for (int v = 0; v < 22; v++) begin
      step(tbl[v].r, 1'b0);
      check($sformatf("vec%0d gnt", v),       32'(gnt),       32'(tbl[v].g));
      check($sformatf("vec%0d gnt_code", v),  32'(gnt_code),  32'(tbl[v].c));
      check($sformatf("vec%0d gnt_valid", v), 32'(gnt_valid), 32'(tbl[v].v));
      check($sformatf("vec%0d bus_busy", v),  32'(bus_busy),  32'(tbl[v].b));
    end

    // Clear pulsed mid-grant while MDR owns the bus.
    step(24'h200000, 1'b0);
    check("mdr gnt",      32'(gnt),      32'h200000);
    check("mdr gnt_code", 32'(gnt_code), 32'd21);
    #1;
    clear = 1'b1;
    #1;
    check("async clear gnt",       32'(gnt),       32'd0);
    check("async clear gnt_code",  32'(gnt_code),  32'd0);
    check("async clear gnt_valid", 32'(gnt_valid), 32'd0);
    check("async clear bus_busy",  32'(bus_busy),  32'd0);
    step(24'h200001, 1'b1);
    step(24'h200001, 1'b0);
    check("post clear gnt",      32'(gnt),      32'h000001);
    check("post clear gnt_code", 32'(gnt_code), 32'd0);

    // Sole requester PC held continuously.
    step('0, 1'b1);
    for (int s = 1; s <= 15; s++) begin
      step(24'h100000, 1'b0);
`ifdef BUS_ARB_HOLD_LIMIT_EN
      exp_g = (((s - 1) % (MH + 1)) < MH) ? 24'h100000 : 24'h000000;
`else
      exp_g = 24'h100000;
`endif
      check($sformatf("pc hold s%0d gnt", s), 32'(gnt), 32'(exp_g));
      compare_model($sformatf("pc hold s%0d", s));
    end

    // Randomised traffic against the model plus structural properties.
    step('0, 1'b1);
    r      = '0;
    prev_g = '0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      mask = N'($urandom & $urandom);
      r    = r ^ mask;
      c    = ($urandom_range(0, 999) == 0);
      step(r, c);
      compare_model("rand");
      check("rand onehot0", 32'($onehot0(gnt)), 32'd1);
      check("rand dead gap", 32'((prev_g != '0) && (gnt != prev_g) && (gnt != '0)), 32'd0);
      new_grant = (gnt != '0) && (prev_g == '0);
      maxw = 0;
      for (int i = 0; i < N; i++) begin
        if (c || !r[i] || gnt[i]) wt[i] = 0;
        else if (new_grant) wt[i]++;
        if (wt[i] > maxw) maxw = wt[i];
      end
      check("rand starvation", 32'(maxw > N), 32'd0);
      prev_g = gnt;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
